// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer. Owns green/yellow/all-red timing,
// cross-call green truncation and an emergency all-red hold. Lamps, phase
// and sec_left are registered from the next-state decode so they change on
// the same edge as the state register.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   INIT      | one cycle after reset, both red
//   NS_GREEN  | north-south green, east-west red
//   NS_YELLOW | north-south yellow, east-west red
//   ALLRED_A  | clearance before east-west green
//   EW_GREEN  | east-west green, north-south red
//   EW_YELLOW | east-west yellow, north-south red
//   ALLRED_B  | clearance before north-south green
//   HOLD      | emergency all-red, held while hold=1
module intersection_scheduler #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int GREEN_TIME   = 10,
  parameter int MIN_GREEN    = 4,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2
) (
  input  logic       clk_125M,
  input  logic       rstn,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       hold,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase,
  output logic [3:0] sec_left,
  output logic       sec_tick
);

  localparam int              PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [3:0]      GREEN_S   = 4'(GREEN_TIME);
  localparam logic [3:0]      YELLOW_S  = 4'(YELLOW_TIME);
  localparam logic [3:0]      ALLRED_S  = 4'(ALL_RED_TIME);
  localparam logic [4:0]      MIN_S     = 5'(MIN_GREEN);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALLRED_B  = 3'd6,
    HOLD      = 3'd7
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [3:0]    elapsed;
  logic          call_ns;
  logic          call_ew;
  logic          tick;
  logic          last_sec;
  logic          min_met;
  logic          entry;
  logic          timed;
  logic          in_green;
  logic [3:0]    load_val;
  logic [5:0]    lamp_nxt;
  logic [5:0]    lamp_q;

  assign tick     = (presc == PRESC_MAX);
  assign sec_tick = tick;
  assign last_sec = tick && (sec_left == 4'd1);
  assign min_met  = ({1'b0, elapsed} + 5'd1) >= MIN_S;
  assign entry    = (state_nxt != state);
  assign timed    = (state != INIT) && (state != HOLD);
  assign in_green = (state == NS_GREEN) || (state == EW_GREEN);
  assign phase    = state;
  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamp_q;

  // State register with lamps registered alongside it
  always_ff @(posedge clk_125M or negedge rstn) begin
    if (!rstn) begin
      state  <= INIT;
      lamp_q <= 6'b100_100;
    end else begin
      state  <= state_nxt;
      lamp_q <= lamp_nxt;
    end
  end

  // Next-state decode: timed expiry, cross-call truncation and hold
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:      state_nxt = ALLRED_B;
      NS_GREEN:  if (hold || last_sec || (tick && call_ew && min_met)) state_nxt = NS_YELLOW;
      NS_YELLOW: if (last_sec) state_nxt = ALLRED_A;
      ALLRED_A:  if (last_sec) state_nxt = hold ? HOLD : EW_GREEN;
      EW_GREEN:  if (hold || last_sec || (tick && call_ns && min_met)) state_nxt = EW_YELLOW;
      EW_YELLOW: if (last_sec) state_nxt = ALLRED_B;
      ALLRED_B:  if (last_sec) state_nxt = hold ? HOLD : NS_GREEN;
      HOLD:      if (!hold) state_nxt = ALLRED_B;
      default:   state_nxt = INIT;
    endcase
  end

  // Output decode from the next state: lamp set and countdown load value
  always_comb begin
    lamp_nxt = 6'b100_100;
    load_val = 4'd0;
    case (state_nxt)
      NS_GREEN:  begin lamp_nxt = 6'b001_100; load_val = GREEN_S;  end
      NS_YELLOW: begin lamp_nxt = 6'b010_100; load_val = YELLOW_S; end
      EW_GREEN:  begin lamp_nxt = 6'b100_001; load_val = GREEN_S;  end
      EW_YELLOW: begin lamp_nxt = 6'b100_010; load_val = YELLOW_S; end
      ALLRED_A,
      ALLRED_B:  begin lamp_nxt = 6'b100_100; load_val = ALLRED_S; end
      default:   begin lamp_nxt = 6'b100_100; load_val = 4'd0;     end
    endcase
  end

  // Prescaler, countdown, green elapsed time and call latches
  always_ff @(posedge clk_125M or negedge rstn) begin
    if (!rstn) begin
      presc    <= '0;
      sec_left <= 4'd0;
      elapsed  <= 4'd0;
      call_ns  <= 1'b0;
      call_ew  <= 1'b0;
    end else begin
      if (entry) begin
        presc    <= '0;
        sec_left <= load_val;
        elapsed  <= 4'd0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && timed)    sec_left <= sec_left - 4'd1;
        if (tick && in_green) elapsed  <= elapsed + 4'd1;
      end
      // a fresh request wins over the clear on green entry
      if (req_ns && state != NS_GREEN)
        call_ns <= 1'b1;
      else if (state_nxt == NS_GREEN && state != NS_GREEN)
        call_ns <= 1'b0;
      if (req_ew && state != EW_GREEN)
        call_ew <= 1'b1;
      else if (state_nxt == EW_GREEN && state != EW_GREEN)
        call_ew <= 1'b0;
    end
  end

endmodule
